difficulty_menu_ctrl: RTL and testbench

Sequencer for the difficulty-selection screen. Debounces the Basys 3 up, down and centre buttons and moves the highlighted row (Easy, Medium or Hard). On a centre press it runs a timed confirmation phase, latches the chosen difficulty, pulses game start and hands the display to the game. It sits between the raw button pins and the difficulty pixel generator, whose 2-bit selection input it drives. It also drives the top-level screen mux through menu_active.

---
 rtl/difficulty_menu_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_difficulty_menu_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/difficulty_menu_ctrl.sv
// Difficulty-selection screen sequencer.
// Debounces the Up/Down/Centre buttons, moves the highlighted row, runs a
// timed confirmation phase, latches the difficulty and hands the display to
// the game until the game core reports game over.
module difficulty_menu_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CONFIRM_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       game_over,
    output logic [1:0] selection,
    output logic [1:0] difficulty,
    output logic       menu_active,
    output logic       flash,
    output logic       game_start
);

    // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Confirm timer is loaded with CONFIRM_CYCLES-1 and counts down to 0.
    localparam int TW = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;

    localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CONFIRM_CYCLES - 1);

    // Button index mapping used throughout: 0 = Up, 1 = Down, 2 = Centre.
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_SEL  = 2;

    typedef enum logic [1:0] {
        ST_MENU    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;

    logic [2:0] raw_btn;
    logic [2:0] press;

    assign raw_btn = {btn_sel, btn_down, btn_up};

    // ------------------------------------------------------------------
    // Per-button input path: synchroniser, debouncer, rising-edge event.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          deb_reg;
            logic          deb_d_reg;
            logic          press_reg;
            logic [CW-1:0] cnt_reg;

            // Two-flop synchroniser for the asynchronous raw button pin.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw_btn[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Accept a level change only after it has persisted long enough;
            // any agreement between synced and debounced restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    deb_reg <= 1'b0;
                    cnt_reg <= '0;
                end else if (sync2_reg != deb_reg) begin
                    if (cnt_reg == DEB_MAX) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            // One-cycle press pulse on the debounced rising edge; releases
            // produce nothing.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    deb_d_reg <= 1'b0;
                    press_reg <= 1'b0;
                end else begin
                    deb_d_reg <= deb_reg;
                    press_reg <= deb_reg & ~deb_d_reg;
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Menu sequencer.
    // ------------------------------------------------------------------
    state_t        state_reg,       state_next;
    logic [1:0]    selection_reg,   selection_next;
    logic [1:0]    difficulty_reg,  difficulty_next;
    logic [TW-1:0] timer_reg,       timer_next;
    logic          menu_active_reg, menu_active_next;
    logic          flash_reg,       flash_next;
    logic          game_start_reg,  game_start_next;

    logic up_evt;
    logic down_evt;
    logic sel_evt;

    assign up_evt   = press[BTN_UP];
    assign down_evt = press[BTN_DOWN];
    assign sel_evt  = press[BTN_SEL];

    // State and output registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_MENU;
            selection_reg   <= 2'd0;
            difficulty_reg  <= 2'd0;
            timer_reg       <= '0;
            menu_active_reg <= 1'b1;
            flash_reg       <= 1'b0;
            game_start_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            selection_reg   <= selection_next;
            difficulty_reg  <= difficulty_next;
            timer_reg       <= timer_next;
            menu_active_reg <= menu_active_next;
            flash_reg       <= flash_next;
            game_start_reg  <= game_start_next;
        end
    end

    // Next-state and next-output logic for MENU / CONFIRM / PLAY.
    always_comb begin
        state_next       = state_reg;
        selection_next   = selection_reg;
        difficulty_next  = difficulty_reg;
        timer_next       = timer_reg;
        menu_active_next = menu_active_reg;
        flash_next       = flash_reg;
        game_start_next  = 1'b0;

        case (state_reg)
            ST_MENU: begin
                menu_active_next = 1'b1;
                flash_next       = 1'b0;
                if (sel_evt) begin
                    // Centre wins over a simultaneous Up/Down.
                    difficulty_next = selection_reg;
                    timer_next      = TIMER_LOAD;
                    flash_next      = 1'b1;
                    state_next      = ST_CONFIRM;
                end else if (up_evt && !down_evt) begin
                    selection_next = (selection_reg == 2'd0) ? 2'd2
                                                             : selection_reg - 2'd1;
                end else if (down_evt && !up_evt) begin
                    selection_next = (selection_reg >= 2'd2) ? 2'd0
                                                             : selection_reg + 2'd1;
                end
            end

            ST_CONFIRM: begin
                // Button events are dropped here; only the timer runs.
                if (timer_reg == '0) begin
                    state_next       = ST_PLAY;
                    game_start_next  = 1'b1;
                    menu_active_next = 1'b0;
                    flash_next       = 1'b0;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            ST_PLAY: begin
                menu_active_next = 1'b0;
                flash_next       = 1'b0;
                if (game_over) begin
                    // Highlight comes back on the difficulty just played.
                    state_next       = ST_MENU;
                    menu_active_next = 1'b1;
                    selection_next   = difficulty_reg;
                end
            end

            default: begin
                state_next       = ST_MENU;
                menu_active_next = 1'b1;
                flash_next       = 1'b0;
            end
        endcase

        // Row 3 does not exist; recover to Easy if it ever appears.
        if (selection_reg == 2'd3) begin
            selection_next = 2'd0;
        end
    end

    assign selection   = selection_reg;
    assign difficulty  = difficulty_reg;
    assign menu_active = menu_active_reg;
    assign flash       = flash_reg;
    assign game_start  = game_start_reg;

endmodule

// File: tb/tb_difficulty_menu_ctrl.sv
// Self-checking bench for difficulty_menu_ctrl with a behavioural model.
module tb_difficulty_menu_ctrl;

    localparam int DEB  = 4;
    localparam int CONF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_sel = 1'b0;
    logic       game_over = 1'b0;
    logic [1:0] selection;
    logic [1:0] difficulty;
    logic       menu_active;
    logic       flash;
    logic       game_start;

    difficulty_menu_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CONFIRM_CYCLES (CONF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_sel    (btn_sel),
        .game_over  (game_over),
        .selection  (selection),
        .difficulty (difficulty),
        .menu_active(menu_active),
        .flash      (flash),
        .game_start (game_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 menu, 1 confirm, 2 play
    int m_mode, m_left, m_sel, m_diff, m_menu, m_flash, m_start;
    // hist[b][0] is the newest raw sample, hist[b][k] is k edges older.
    int hist[3][DEB+1];
    int deb_lvl[3];
    int rise[3];
    int evt[3];

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_sel = 0; m_diff = 0;
        m_menu = 1; m_flash = 0; m_start = 0;
        for (int b = 0; b < 3; b++) begin
            deb_lvl[b] = 0; rise[b] = 0; evt[b] = 0;
            for (int k = 0; k <= DEB; k++) hist[b][k] = 0;
        end
    endtask

    task automatic model_edge(input int r_up, input int r_down, input int r_sel, input int go);
        int raw[3];
        int flip;
        raw[0] = r_up; raw[1] = r_down; raw[2] = r_sel;
        m_start = 0;
        case (m_mode)
            0: begin
                if (evt[2] != 0) begin
                    m_diff = m_sel; m_mode = 1; m_left = CONF; m_flash = 1;
                end else if (evt[0] != 0 && evt[1] == 0) begin
                    m_sel = (m_sel + 2) % 3;
                end else if (evt[1] != 0 && evt[0] == 0) begin
                    m_sel = (m_sel + 1) % 3;
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2; m_start = 1; m_menu = 0; m_flash = 0;
                end
            end
            default: begin
                if (go != 0) begin
                    m_mode = 0; m_menu = 1;
                end
            end
        endcase
        for (int b = 0; b < 3; b++) begin
            evt[b] = rise[b];
            // A level is accepted once DEB consecutive synchronised samples
            // (raw delayed two edges) all disagree with the current level.
            flip = 1;
            for (int k = 1; k <= DEB; k++)
                if (hist[b][k] == deb_lvl[b]) flip = 0;
            rise[b] = 0;
            if (flip != 0) begin
                deb_lvl[b] = 1 - deb_lvl[b];
                rise[b] = deb_lvl[b];
            end
            for (int k = DEB; k >= 1; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = raw[b];
        end
    endtask

    task automatic compare_all();
        check_val("selection",   int'(selection),   m_sel);
        check_val("difficulty",  int'(difficulty),  m_diff);
        check_val("menu_active", int'(menu_active), m_menu);
        check_val("flash",       int'(flash),       m_flash);
        check_val("game_start",  int'(game_start),  m_start);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(int'(btn_up), int'(btn_down), int'(btn_sel), int'(game_over));
        else       model_reset();
        #1;
        compare_all();
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_up = v;
            1:       btn_down = v;
            default: btn_sel = v;
        endcase
    endtask

    task automatic press(input int which, input int len);
        set_btn(which, 1'b1);
        repeat (len) tick();
        set_btn(which, 1'b0);
        repeat (DEB + 6) tick();
        $display("press btn=%0d selection=%0d difficulty=%0d", which, selection, difficulty);
    endtask

    int first, changes, prev, flash_cnt, start_cnt, seen, len;
    logic [2:0] b;

    initial begin
        model_reset();
        repeat (3) tick();
        check_val("rst_selection", int'(selection), 0);
        check_val("rst_menu_active", int'(menu_active), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: held Down gives exactly one event with the documented latency.
        btn_down = 1'b1;
        first = 0; changes = 0; prev = int'(selection);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (int'(selection) != prev) begin
                changes++;
                if (first == 0) first = i;
                prev = int'(selection);
            end
        end
        check_val("t1_latency", first, 1 + DEB + 3);
        check_val("t1_changes", changes, 1);
        btn_down = 1'b0;
        repeat (DEB + 6) tick();
        $display("hold-down done selection=%0d", selection);

        // 2: wrap in both directions (selection is 1 here; Up twice reaches 2).
        press(0, DEB + 2);
        check_val("t2_up_to_0", int'(selection), 0);
        press(0, DEB + 2);
        check_val("t2_up_wrap", int'(selection), 2);
        for (int k = 0; k < 4; k++) begin
            press(1, DEB + 2);
            check_val("t2_down", int'(selection), k % 3);
        end

        // 3: short glitches never pass the debouncer.
        for (int k = 0; k < 10; k++) begin
            btn_up = 1'b1; repeat (2) tick();
            btn_up = 1'b0; repeat (2) tick();
        end
        check_val("t3_glitch", int'(selection), 0);
        $display("glitch train done selection=%0d", selection);

        // 4: select Medium, confirm, ignore buttons in CONFIRM and PLAY.
        press(1, DEB + 2);
        check_val("t4_medium", int'(selection), 1);
        flash_cnt = 0; start_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            btn_sel  = (i < DEB + 2);
            btn_up   = (i >= 8 && i < 14);
            btn_down = (i >= 20 && i < 26);
            tick();
            flash_cnt += int'(flash);
            start_cnt += int'(game_start);
        end
        btn_sel = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        check_val("t4_flash_len", flash_cnt, CONF);
        check_val("t4_start_len", start_cnt, 1);
        check_val("t4_difficulty", int'(difficulty), 1);
        check_val("t4_sel_frozen", int'(selection), 1);
        check_val("t4_menu_off", int'(menu_active), 0);
        $display("confirm/play done difficulty=%0d", difficulty);

        // 5: game_over returns to MENU; a second one in MENU does nothing.
        game_over = 1'b1; tick(); game_over = 1'b0; tick();
        check_val("t5_menu_on", int'(menu_active), 1);
        check_val("t5_sel_kept", int'(selection), 1);
        game_over = 1'b1; tick(); game_over = 1'b0; tick();
        check_val("t5_go_in_menu", int'(menu_active), 1);
        press(1, DEB + 2);
        check_val("t5_menu_live", int'(selection), 2);

        // 6: reset in the middle of CONFIRM, then Up+Centre together.
        btn_sel = 1'b1;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            tick();
            if (flash) seen = 1;
        end
        btn_sel = 1'b0;
        check_val("t6_confirm_seen", seen, 1);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        start_cnt = 0;
        repeat (3) begin
            tick();
            start_cnt += int'(game_start);
        end
        check_val("t6_no_start", start_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        btn_up = 1'b1; btn_sel = 1'b1;
        repeat (DEB + 2) tick();
        btn_up = 1'b0; btn_sel = 1'b0;
        repeat (3) tick();
        check_val("t6_flash", int'(flash), 1);
        check_val("t6_difficulty", int'(difficulty), 0);
        check_val("t6_selection", int'(selection), 0);
        repeat (CONF + 4) tick();
        $display("reset-in-confirm done menu_active=%0d", menu_active);

        // Random phase: arbitrary button combinations and game_over pulses.
        for (int n = 0; n < 250; n++) begin
            len = int'($urandom_range(1, 9));
            b = 3'($urandom_range(0, 7));
            if (b[2] && ($urandom_range(0, 3) != 0)) b[2] = 1'b0;
            btn_up = b[0]; btn_down = b[1]; btn_sel = b[2];
            repeat (len) begin
                game_over = ($urandom_range(0, 15) == 0);
                tick();
            end
            game_over = 1'b0;
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        repeat (DEB + 6) tick();
        $display("random phase done selection=%0d difficulty=%0d", selection, difficulty);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
